// File: rtl/fft_bf_stage_gated.sv
// -----------------------------------------------------------------------------
// fft_bf_stage_gated
//
// Radix-2 butterfly stage wrapper for the FFT pipeline. Processes LANES complex
// samples per clock. A single din_valid pulse while idle opens a frame window of
// exactly FRAME_CLKS clocks; every clock inside that window is a valid sample,
// whatever din_valid does afterwards. Output width grows by one bit so the
// add/subtract can never overflow.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset (clears outputs, state, counter)
//   din_valid   frame start strobe; only acts in IDLE
//   bypass      1 = sign-extended pass-through, 0 = butterfly (per clock)
//   din_r/din_i signed [IN_W-1:0] x LANES real / imag inputs
//   dout_r/i    signed [IN_W:0] x LANES registered outputs
//   dout_valid  outputs hold a fresh frame sample
//   dout_idx    sample index of the registered sample (holds when not valid)
//   frame_done  one-clock pulse together with the last sample of a frame
//   retrig_err  one-clock pulse: din_valid seen while a frame was running
//   dbg_state   current FSM state (0 = IDLE, 1 = RUN) for checkers
//
// Valid/ready semantics: there is no ready. The downstream stage must accept
// every cycle in which dout_valid = 1; outputs are only meaningful on those
// cycles and simply hold otherwise. Latency from input to output is 1 clock.
// -----------------------------------------------------------------------------
module fft_bf_stage_gated #(
  parameter int IN_W       = 13,
  parameter int LANES      = 16,
  parameter int SPAN       = 8,
  parameter int FRAME_CLKS = 32,
  parameter int IDX_W      = $clog2(FRAME_CLKS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   din_valid,
  input  logic                   bypass,
  input  logic signed [IN_W-1:0] din_r [LANES],
  input  logic signed [IN_W-1:0] din_i [LANES],
  output logic signed [IN_W:0]   dout_r [LANES],
  output logic signed [IN_W:0]   dout_i [LANES],
  output logic                   dout_valid,
  output logic [IDX_W-1:0]       dout_idx,
  output logic                   frame_done,
  output logic                   retrig_err,
  output logic                   dbg_state
);

  localparam int OUT_W = IN_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CLKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Per-cycle control derived from the FSM.
  logic             gated_valid;
  logic             last_sample;
  logic             retrig_now;
  logic [IDX_W-1:0] sample_idx;

  // Next values for the data registers.
  logic signed [OUT_W-1:0] nxt_r [LANES];
  logic signed [OUT_W-1:0] nxt_i [LANES];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and gating
  // cnt_q holds the index of the sample being taken in the current RUN cycle.
  // The start cycle in IDLE is sample 0, so RUN begins with cnt = 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gated_valid = 1'b0;
    last_sample = 1'b0;
    retrig_now  = 1'b0;
    sample_idx  = cnt_q;

    case (state_q)
      IDLE: begin
        sample_idx = '0;
        if (din_valid) begin
          gated_valid = 1'b1;
          state_d     = RUN;
          cnt_d       = IDX_W'(1);
        end
      end

      RUN: begin
        gated_valid = 1'b1;
        // A strobe here does not affect gating; it is only reported.
        retrig_now  = din_valid;
        if (cnt_q == LAST_IDX) begin
          last_sample = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Butterfly datapath. Lanes with (k mod 2*SPAN) < SPAN are the "top" of a
  // pair and produce the sum; their partner k+SPAN produces the difference.
  // Operands are widened first so the result always fits in OUT_W bits.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [OUT_W-1:0] self_r, self_i;
    logic signed [OUT_W-1:0] bf_r, bf_i;

    assign self_r = OUT_W'(din_r[k]);
    assign self_i = OUT_W'(din_i[k]);

    if ((k % (2 * SPAN)) < SPAN) begin : g_sum
      logic signed [OUT_W-1:0] pair_r, pair_i;
      assign pair_r = OUT_W'(din_r[k + SPAN]);
      assign pair_i = OUT_W'(din_i[k + SPAN]);
      assign bf_r   = self_r + pair_r;
      assign bf_i   = self_i + pair_i;
    end else begin : g_diff
      logic signed [OUT_W-1:0] pair_r, pair_i;
      assign pair_r = OUT_W'(din_r[k - SPAN]);
      assign pair_i = OUT_W'(din_i[k - SPAN]);
      assign bf_r   = pair_r - self_r;
      assign bf_i   = pair_i - self_i;
    end

    assign nxt_r[k] = bypass ? self_r : bf_r;
    assign nxt_i[k] = bypass ? self_i : bf_i;
  end

  // ---------------------------------------------------------------------------
  // Output registers. Data and index load only on gated-valid cycles; the
  // status pulses are registered every cycle so they line up with the data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_idx   <= '0;
      frame_done <= 1'b0;
      retrig_err <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        dout_r[k] <= '0;
        dout_i[k] <= '0;
      end
    end else begin
      dout_valid <= gated_valid;
      frame_done <= last_sample;
      retrig_err <= retrig_now;
      if (gated_valid) begin
        dout_idx <= sample_idx;
        for (int k = 0; k < LANES; k++) begin
          dout_r[k] <= nxt_r[k];
          dout_i[k] <= nxt_i[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bf_stage_gated.sv
// -----------------------------------------------------------------------------
// tb_fft_bf_stage_gated
//
// Driver tasks issue one input cycle per falling edge and push the expected
// response (status every cycle, data record on valid samples) into queues.
// A monitor process checks the DUT 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fft_bf_stage_gated;

  localparam int IN_W  = 13;
  localparam int LANES = 16;
  localparam int SPAN  = 8;
  localparam int FRAME = 32;
  localparam int IDX_W = 5;
  localparam int OW    = IN_W + 1;

  typedef struct packed {
    logic [LANES-1:0][OW-1:0] r;
    logic [LANES-1:0][OW-1:0] i;
    logic [IDX_W-1:0]         idx;
  } rec_t;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                   clk;
  logic                   rstn;
  logic                   din_valid;
  logic                   bypass;
  logic signed [IN_W-1:0] din_r [LANES];
  logic signed [IN_W-1:0] din_i [LANES];
  logic signed [IN_W:0]   dout_r [LANES];
  logic signed [IN_W:0]   dout_i [LANES];
  logic                   dout_valid;
  logic [IDX_W-1:0]       dout_idx;
  logic                   frame_done;
  logic                   retrig_err;
  logic                   dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_bf_stage_gated #(
    .IN_W(IN_W), .LANES(LANES), .SPAN(SPAN), .FRAME_CLKS(FRAME), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .bypass(bypass),
    .din_r(din_r), .din_i(din_i), .dout_r(dout_r), .dout_i(dout_i),
    .dout_valid(dout_valid), .dout_idx(dout_idx), .frame_done(frame_done),
    .retrig_err(retrig_err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  rec_t       exp_q[$];
  logic [2:0] stat_q[$];   // {valid, retrig_err, frame_done}
  int         total = 0;
  int         bad   = 0;
  logic       mon_en = 1'b0;
  logic [IDX_W-1:0] hold_idx = '0;

  // Frame-timing model of the block as seen from outside.
  logic m_run = 1'b0;
  int   m_cnt = 0;

  logic [LANES-1:0][IN_W-1:0] cur_r;
  logic [LANES-1:0][IN_W-1:0] cur_i;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [OW-1:0] lane_exp(
    input logic [LANES-1:0][IN_W-1:0] v, input int k, input logic byp);
    logic signed [OW-1:0] a, b;
    if (byp) begin
      a = $signed(v[k]);
      return a;
    end
    if ((k % (2 * SPAN)) < SPAN) begin
      a = $signed(v[k]);
      b = $signed(v[k + SPAN]);
      return a + b;
    end
    a = $signed(v[k - SPAN]);
    b = $signed(v[k]);
    return a - b;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic apply(input logic dv, input logic byp);
    logic gv, err, last;
    int   idx;
    rec_t e;
    din_valid = dv;
    bypass    = byp;
    for (int k = 0; k < LANES; k++) begin
      din_r[k] = cur_r[k];
      din_i[k] = cur_i[k];
    end
    gv   = m_run || dv;
    err  = m_run && dv;
    idx  = m_run ? m_cnt : 0;
    last = gv && (idx == FRAME - 1);
    stat_q.push_back({gv, err, last});
    if (gv) begin
      e.idx = IDX_W'(idx);
      for (int k = 0; k < LANES; k++) begin
        e.r[k] = lane_exp(cur_r, k, byp);
        e.i[k] = lane_exp(cur_i, k, byp);
      end
      exp_q.push_back(e);
      if (last) begin
        m_run = 1'b0;
        m_cnt = 0;
      end else begin
        m_run = 1'b1;
        m_cnt = idx + 1;
      end
    end
  endtask

  task automatic drive(input logic dv, input logic byp);
    @(negedge clk);
    apply(dv, byp);
  endtask

  task automatic clear_cur();
    cur_r = '0;
    cur_i = '0;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < LANES; k++) begin
      cur_r[k] = IN_W'($urandom_range(0, 8191));
      cur_i[k] = IN_W'($urandom_range(0, 8191));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    stat_q.delete();
    exp_q.delete();
    m_run    = 1'b0;
    m_cnt    = 0;
    hold_idx = '0;
    mon_en   = 1'b1;
    clear_cur();
    apply(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_idx"}, dout_idx, '0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_err"}, retrig_err, 1'b0);
    chk({tag, "_state"}, dbg_state, 1'b0);
    chk_int({tag, "_r0"}, int'(dout_r[0]), 0);
    chk_int({tag, "_r8"}, int'(dout_r[8]), 0);
    chk_int({tag, "_i15"}, int'(dout_i[15]), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic check_cycle();
    logic [2:0] st;
    rec_t       e;
    logic [LANES-1:0][OW-1:0] ar, ai;
    if (stat_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL stat_underflow: no expectation queued (t=%0t)", $time);
      return;
    end
    st = stat_q.pop_front();
    chk("dout_valid", dout_valid, st[2]);
    chk("retrig_err", retrig_err, st[1]);
    chk("frame_done", frame_done, st[0]);
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL data_underflow: dout_valid=1 with empty queue (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < LANES; k++) begin
          ar[k] = dout_r[k];
          ai[k] = dout_i[k];
        end
        chk("dout_idx", dout_idx, e.idx);
        chk("dout_r", ar, e.r);
        chk("dout_i", ai, e.i);
        hold_idx = e.idx;
      end
    end else begin
      chk("dout_idx_hold", dout_idx, hold_idx);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) check_cycle();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rstn      = 1'b0;
    din_valid = 1'b0;
    bypass    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      din_r[k] = '0;
      din_i[k] = '0;
    end
    clear_cur();

    #3;
    check_reset_outputs("rst");
    release_reset();
    repeat (2) drive(1'b0, 1'b0);

    // Single frame with hand-computed butterfly corners.
    clear_cur();
    cur_r[0] = IN_W'(4095);
    cur_r[8] = IN_W'(4095);
    cur_i[0] = IN_W'(-4096);
    cur_i[8] = IN_W'(4095);
    drive(1'b1, 1'b0);
    @(posedge clk); #2;
    chk_int("bf_max_r0", int'(dout_r[0]), 8190);
    chk_int("bf_max_r8", int'(dout_r[8]), 0);
    chk_int("bf_max_i0", int'(dout_i[0]), -1);
    chk_int("bf_max_i8", int'(dout_i[8]), -8191);

    clear_cur();
    cur_r[0] = IN_W'(-4096);
    cur_r[8] = IN_W'(4095);
    cur_i[0] = IN_W'(4095);
    cur_i[8] = IN_W'(4095);
    drive(1'b0, 1'b0);
    @(posedge clk); #2;
    chk_int("bf_min_r0", int'(dout_r[0]), -1);
    chk_int("bf_min_r8", int'(dout_r[8]), -8191);
    chk_int("bf_min_i0", int'(dout_i[0]), 8190);
    chk_int("bf_min_i8", int'(dout_i[8]), 0);

    set_pattern();
    cur_r[3] = IN_W'(-5);
    drive(1'b0, 1'b1);
    @(posedge clk); #2;
    chk_int("byp_r3", int'(dout_r[3]), -5);

    for (int c = 3; c < FRAME; c++) begin
      set_pattern();
      drive(1'b0, (c % 7) == 0);
    end
    repeat (3) drive(1'b0, 1'b0);

    // Retrigger: din_valid held for 40 cycles.
    for (int c = 0; c < 40; c++) begin
      set_pattern();
      drive(1'b1, 1'b0);
    end
    for (int c = 40; c < 2 * FRAME; c++) begin
      set_pattern();
      drive(1'b0, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0);

    // Back-to-back frames.
    for (int c = 0; c < 2 * FRAME; c++) begin
      set_pattern();
      drive((c == 0) || (c == FRAME), (c % 5) == 0);
    end
    repeat (3) drive(1'b0, 1'b0);

    // Reset in the middle of a frame.
    for (int c = 0; c < 10; c++) begin
      set_pattern();
      drive(c == 0, 1'b0);
    end
    @(posedge clk); #2;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (5) drive(1'b0, 1'b0);

    // Fresh frame after recovery.
    for (int c = 0; c < FRAME; c++) begin
      set_pattern();
      drive(c == 0, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0);

    @(posedge clk); #2;
    mon_en = 1'b0;
    chk_int("exp_q_empty", exp_q.size(), 0);
    chk_int("stat_q_empty", stat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
